// File: rtl/fetch_controller_pkg.sv
// ============================================================================
// Module   : fetch_controller_pkg
// Brief    : Shared types, opcode constant and jump-target helpers for the
//            instruction fetch controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_controller_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam logic [5:0] OPC_J = 6'b000010;

    // J-type target: region bits come from the sequential pc, not the jump pc
    function automatic logic [31:0] jump_target(input logic [31:0] pc,
                                                input logic [31:0] instr);
        logic [31:0] pc_plus4;
        pc_plus4 = pc + 32'd4;
        return {pc_plus4[31:28], instr[25:0], 2'b00};
    endfunction

    function automatic logic is_self_jump(input logic [31:0] pc,
                                          input logic [31:0] instr);
        return (instr[31:26] == OPC_J) && (jump_target(pc, instr) == pc);
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_controller_if.sv
// ============================================================================
// Module   : fetch_controller_if
// Brief    : Instruction-memory, redirect and output handshake bundle of the
//            fetch controller (master = controller, slave = environment).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_controller_if;
    logic        enable;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        misalign_err;
    logic        halted;

    modport master (
        input  enable, imem_instr, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_instr, out_pc, misalign_err, halted
    );

    modport slave (
        output enable, imem_instr, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_instr, out_pc, misalign_err, halted
    );
endinterface

`default_nettype wire

// File: rtl/fetch_buffer.sv
// ============================================================================
// Module   : fetch_buffer
// Brief    : Synchronous FIFO with single-cycle flush; DEPTH a power of two.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_buffer #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             flush,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] push_data,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] head,
    output logic                  full,
    output logic                  empty
);
    localparam int c_AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_rd;
    logic [c_AW-1:0]  r_wr;
    logic [c_AW:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign full      = (r_count == (c_AW + 1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign head      = r_mem[r_rd];
    assign w_do_pop  = pop && !empty;
    assign w_do_push = push && (!full || w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_rd    <= '0;
            r_wr    <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge clk) begin
        if (w_do_push && !flush) r_mem[r_wr] <= push_data;
    end

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
// Module   : fetch_controller
// Brief    : Sequential instruction fetch into a small buffer with redirect
//            flush; self-jump halt detection when HALT_DETECT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller
    import fetch_controller_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fetch_controller_if.master bus
);
    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_pc;
    logic [31:0] w_pc_nxt;
    logic        r_misalign;
    logic        w_push;
    logic        w_pop;
    logic        w_full;
    logic        w_empty;
    logic        w_slot_free;
    logic        w_halt_hit;
    logic [63:0] w_head;

    assign w_pop       = !w_empty && bus.out_ready;
    assign w_slot_free = !w_full || w_pop;

`ifdef HALT_DETECT_EN
    assign w_halt_hit = is_self_jump(r_pc, bus.imem_instr);
    assign bus.halted = (r_state == ST_HALT);
`else
    assign w_halt_hit = 1'b0;
    assign bus.halted = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_push      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.enable) w_state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                if (!bus.enable) w_state_nxt = ST_IDLE;
                if (w_slot_free) begin
                    w_push = 1'b1;
                    // A self-jump is kept in the buffer but pc is frozen on it
                    if (w_halt_hit) w_state_nxt = ST_HALT;
                    else            w_pc_nxt    = r_pc + 32'd4;
                end
            end
            ST_HALT: begin
                w_state_nxt = ST_HALT;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (bus.redirect_valid) begin
            w_push      = 1'b0;
            w_pc_nxt    = {bus.redirect_pc[31:2], 2'b00};
            w_state_nxt = bus.enable ? ST_FETCH : ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_misalign <= bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
        end
    end

    fetch_buffer #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (64)
    ) u_buffer (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.redirect_valid),
        .push      (w_push),
        .push_data ({bus.imem_instr, r_pc}),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty)
    );

    assign bus.imem_addr    = r_pc;
    assign bus.out_valid    = !w_empty;
    assign bus.out_instr    = w_empty ? 32'h0 : w_head[63:32];
    assign bus.out_pc       = w_empty ? 32'h0 : w_head[31:0];
    assign bus.misalign_err = r_misalign;

endmodule

`default_nettype wire

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, address of the first fetch after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, fetch-buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port enable  input  1  fetch permitted while high.
REQ-006 SHALL have port imem_addr  output  32  byte address to the combinational instruction memory.
REQ-007 SHALL have port imem_instr  input  32  instruction word for imem_addr, valid the same cycle.
REQ-008 SHALL have port redirect_valid  input  1  branch/jump taken; flush and refetch.
REQ-009 SHALL have port redirect_pc  input  32  redirect target byte address.
REQ-010 SHALL have port out_valid  output  1  buffer head holds an instruction.
REQ-011 SHALL have port out_ready  input  1  consumer accepts the head this cycle.
REQ-012 SHALL have port out_instr  output  32  head instruction word.
REQ-013 SHALL have port out_pc  output  32  head instruction address.
REQ-014 SHALL have port misalign_err  output  1  one-cycle pulse on redirect_pc[1:0] != 0.
REQ-015 SHALL have port halted  output  1  fetch stopped on self-jump.

Function
REQ-016 SHALL implement states IDLE, FETCH, HALT; IDLE->FETCH when enable=1; FETCH->IDLE when enable=0 (buffer and pc retained).
REQ-017 SHALL drive imem_addr = pc in every state.
REQ-018 In FETCH with buffer not full and no redirect, SHALL push {imem_instr, pc} and set pc <= pc+4 (32-bit modulo; 32'hFFFF_FFFC wraps to 0).
REQ-019 SHALL assert out_valid the cycle after the push (fetch-to-output latency 1 cycle); head pops when out_valid && out_ready.
REQ-020 With buffer full, SHALL neither push nor advance pc; push and pop in the same cycle are both honoured when full (pop frees the slot for that cycle's push).
REQ-021 On redirect_valid, SHALL flush all entries, set pc <= {redirect_pc[31:2], 2'b00}, suppress that cycle's push; a pop handshaking in the same cycle completes before the flush.
REQ-022 SHALL pulse misalign_err for exactly the cycle after a redirect with redirect_pc[1:0] != 0.
REQ-023 Redirect SHALL be accepted in IDLE, FETCH and HALT; in HALT it returns to FETCH if enable=1, else IDLE.
REQ-024 out_instr/out_pc SHALL be zero when out_valid=0.

Reset
REQ-025 With rst=1 at a clock edge: state=IDLE, pc=RESET_PC, buffer empty, out_valid=0, out_instr=0, out_pc=0, misalign_err=0, halted=0.
REQ-026 rst SHALL take priority over redirect_valid, enable and handshakes, including mid-operation.

Configuration
REQ-027 With HALT_DETECT_EN defined: pushing a word with opcode[31:26]=6'b000010 whose target {pc+4[31:28], instr[25:0], 2'b00} equals pc SHALL push it, then enter HALT (no further pushes), halted=1 while in HALT.
REQ-028 Without HALT_DETECT_EN: HALT unreachable, halted tied 0, self-jumps fetched like any instruction.

Structure
REQ-029 Shared package SHALL hold state enum, OPC_J = 6'b000010, and the jump-target helper.
REQ-030 Fetch buffer SHALL be sub-module fetch_buffer (synchronous FIFO with flush, full/empty).

Verification
REQ-031 Reset, enable=1, out_ready=1, mem[0]=32'h2108_00D5 -> out_valid=1 second cycle after enable, out_pc=0, out_instr=32'h2108_00D5; next heads out_pc=4, 8.
REQ-032 out_ready=0 for 10 cycles -> exactly BUF_DEPTH entries (pc 0,4), pc holds at 8, imem_addr=8; out_ready=1 -> in-order drain, no loss/duplication.
REQ-033 redirect_valid with redirect_pc=32'h44 while buffer full -> next cycle out_valid=0, then out_pc=32'h44; no pre-redirect entry appears.
REQ-034 redirect_pc=32'h46 -> misalign_err pulses one cycle, next out_pc=32'h44.
REQ-035 HALT_DETECT_EN, mem[76]=32'h0800_0013 -> entry pc=76 output, halted=1, no fetch past 76; redirect to 0 -> halted=0, refetch from 0.
REQ-036 rst during full buffer + pending redirect -> all REQ-025 values next cycle, fetch restarts at RESET_PC.
